key_expander: RTL and testbench

//  AES-128 key schedule generator. Accepts a 128-bit cipher key and emits round keys 0..NR,
//  one per clock, as write transactions into the round-key store (16 x 128-bit, 4-bit address).

---
 rtl/key_expander_pkg.sv | 34 +++
 rtl/key_expander_if.sv | 33 +++
 rtl/aes_sbox.sv | 35 +++
 rtl/key_expander.sv | 117 +++++++++++
 tb/tb_key_expander.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/key_expander_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : key_expander_pkg
//  Description : Shared types and helpers for the AES-128 key schedule:
//                FSM state encoding, round count, word slicing and xtime.
//  Revision    : 1.0
// ============================================================================
package key_expander_pkg;

  // Number of AES-128 rounds; round keys 0..10 are produced.
  localparam int c_NR_AES128 = 10;

  // Round key and word geometry. Word 0 lives in the top 32 bits.
  localparam int c_KEY_W  = 128;
  localparam int c_WORD_W = 32;
  localparam int c_W0_LSB = 96;
  localparam int c_W1_LSB = 64;
  localparam int c_W2_LSB = 32;
  localparam int c_W3_LSB = 0;

  // Expansion controller states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } kexp_state_t;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1; generates the rcon sequence.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_expander_if.sv
`default_nettype none
// ============================================================================
//  Module      : key_expander_if
//  Description : Start/key request and round-key store write channel of the
//                key expander.
//  Revision    : 1.0
// ============================================================================
interface key_expander_if
  import key_expander_pkg::*;
#(
  parameter int ADDW = 4
);
  logic                start;
  logic [c_KEY_W-1:0]  key;
  logic                we;
  logic [ADDW-1:0]     wadd;
  logic [c_KEY_W-1:0]  wdata;
  logic                busy;
  logic                done;

  // Requester side: issues start/key, observes the store writes and status.
  modport master (
    output start, key,
    input  we, wadd, wdata, busy, done
  );

  // Expander side.
  modport slave (
    input  start, key,
    output we, wadd, wdata, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
//  Module      : aes_sbox
//  Description : Combinational AES forward S-box, one byte in, one byte out.
//                Also used by the cipher SubBytes stage.
//  Revision    : 1.0
// ============================================================================
module aes_sbox (
  input  logic [7:0] i_data,
  output logic [7:0] o_data
);

  localparam logic [7:0] c_SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign o_data = c_SBOX[i_data];

endmodule
`default_nettype wire

// File: rtl/key_expander.sv
`default_nettype none
// ============================================================================
//  Module      : key_expander
//  Description : AES-128 key schedule. Captures a cipher key on start and
//                writes round keys 0..NR into the round-key store, one per
//                clock, then pulses done.
//  Revision    : 1.0
// ============================================================================
module key_expander
  import key_expander_pkg::*;
#(
  parameter int NR   = c_NR_AES128,
  parameter int ADDW = 4              // NR must be below 2**ADDW
) (
  input  logic           clock,
  input  logic           reset_n,
  key_expander_if.slave  bus
);

  localparam logic [ADDW-1:0] c_LAST = ADDW'(NR);

  kexp_state_t          r_state;
  logic                 r_we;
  logic                 r_busy;
  logic                 r_done;
  logic [ADDW-1:0]      r_wadd;   // doubles as the round counter
  logic [7:0]           r_rcon;
  logic [c_KEY_W-1:0]   r_rk;     // current round key, also the write data

  logic [c_WORD_W-1:0]  w_w0, w_w1, w_w2, w_w3;
  logic [c_WORD_W-1:0]  w_rot, w_sub, w_t;
  logic [c_WORD_W-1:0]  w_n0, w_n1, w_n2, w_n3;
  logic [c_KEY_W-1:0]   w_next_rk;

  assign w_w0  = r_rk[c_W0_LSB +: c_WORD_W];
  assign w_w1  = r_rk[c_W1_LSB +: c_WORD_W];
  assign w_w2  = r_rk[c_W2_LSB +: c_WORD_W];
  assign w_w3  = r_rk[c_W3_LSB +: c_WORD_W];

  // RotWord: move the leading byte of w3 to the end.
  assign w_rot = {w_w3[23:0], w_w3[31:24]};

  // SubWord: one S-box per byte of the rotated word.
  for (genvar gi = 0; gi < 4; gi++) begin : g_subword
    aes_sbox u_sbox (
      .i_data (w_rot[8*gi +: 8]),
      .o_data (w_sub[8*gi +: 8])
    );
  end

  assign w_t       = w_sub ^ {r_rcon, 24'h0};
  assign w_n0      = w_w0 ^ w_t;
  assign w_n1      = w_w1 ^ w_n0;
  assign w_n2      = w_w2 ^ w_n1;
  assign w_n3      = w_w3 ^ w_n2;
  assign w_next_rk = {w_n0, w_n1, w_n2, w_n3};

  // Expansion controller: accept a key, walk rounds 0..NR, then pulse done.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_we    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_wadd  <= '0;
      r_rcon  <= 8'h01;
      r_rk    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            // Round key 0 is the cipher key itself.
            r_state <= ST_EXPAND;
            r_we    <= 1'b1;
            r_busy  <= 1'b1;
            r_wadd  <= '0;
            r_rcon  <= 8'h01;
            r_rk    <= bus.key;
          end
        end
        ST_EXPAND: begin
          if (r_wadd == c_LAST) begin
            r_state <= ST_DONE;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_wadd  <= r_wadd + 1'b1;
            r_rk    <= w_next_rk;
            r_rcon  <= xtime(r_rcon);
          end
        end
        ST_DONE: begin
          // start is deliberately not looked at here; a held start is
          // taken on the following IDLE cycle.
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_we    <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.we    = r_we;
  assign bus.wadd  = r_wadd;
  assign bus.wdata = r_rk;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_key_expander.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_expander
//  Description : Directed self-checking bench for key_expander against a
//                behavioural AES-128 key schedule model.
//  Revision    : 1.0
// ============================================================================
module tb_key_expander;

  localparam int c_NR   = 10;
  localparam int c_ADDW = 4;

  localparam logic [127:0] c_KEY_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] c_KEY_ZERO = 128'h0;
  localparam logic [127:0] c_KEY_ALT  = 128'h000102030405060708090a0b0c0d0e0f;

  logic clock;
  logic reset_n;

  key_expander_if #(.ADDW(c_ADDW)) bus ();

  key_expander #(.NR(c_NR), .ADDW(c_ADDW)) u_dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int n_writes = 0;

  logic [7:0]   sb_ref [256];
  logic [127:0] rk_ref [c_NR+1];
  logic [127:0] got    [c_NR+1];

  // Count every store write the DUT issues.
  always @(negedge clock) if (bus.we === 1'b1) n_writes++;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from first principles: multiplicative inverse then affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sb_ref[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  task automatic build_ref(input logic [127:0] k);
    logic [31:0] w0, w1, w2, w3, rw, t;
    logic [7:0]  rc;
    rk_ref[0] = k;
    rc = 8'h01;
    for (int r = 1; r <= c_NR; r++) begin
      w0 = rk_ref[r-1][127:96];
      w1 = rk_ref[r-1][95:64];
      w2 = rk_ref[r-1][63:32];
      w3 = rk_ref[r-1][31:0];
      rw = {w3[23:0], w3[31:24]};
      t  = {sb_ref[rw[31:24]], sb_ref[rw[23:16]], sb_ref[rw[15:8]], sb_ref[rw[7:0]]} ^ {rc, 24'h0};
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      rk_ref[r] = {w0, w1, w2, w3};
      rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
    end
  endtask

  // Called at the negedge where start is (or remains) high; checks the
  // writes in cycles 1..NR+1 after acceptance and done in cycle NR+2.
  // poke_cyc > 0 re-pulses start with another key during that cycle.
  task automatic run_seq(input logic [127:0] k, input string tag, input bit hold,
                         input int poke_cyc);
    int w_start;
    w_start = n_writes;
    build_ref(k);
    for (int c = 1; c <= c_NR + 2; c++) begin
      @(negedge clock);
      if (c <= c_NR + 1) begin
        check($sformatf("%s we c%0d", tag, c), {127'h0, bus.we}, 128'h1);
        check($sformatf("%s wadd c%0d", tag, c), {124'h0, bus.wadd}, 128'(c - 1));
        check($sformatf("%s wdata c%0d", tag, c), bus.wdata, rk_ref[c-1]);
        check($sformatf("%s busy c%0d", tag, c), {127'h0, bus.busy}, 128'h1);
        check($sformatf("%s done c%0d", tag, c), {127'h0, bus.done}, 128'h0);
        got[c-1] = bus.wdata;
      end else begin
        check($sformatf("%s done pulse", tag), {127'h0, bus.done}, 128'h1);
        check($sformatf("%s we at done", tag), {127'h0, bus.we}, 128'h0);
        check($sformatf("%s busy at done", tag), {127'h0, bus.busy}, 128'h0);
      end
      if (c == 1 && !hold) begin
        bus.start = 1'b0;
        bus.key   = ~k;
      end
      if (poke_cyc > 0 && c == poke_cyc) begin
        bus.start = 1'b1;
        bus.key   = c_KEY_ALT;
      end
      if (poke_cyc > 0 && c == poke_cyc + 1) begin
        bus.start = 1'b0;
        bus.key   = ~k;
      end
    end
    check($sformatf("%s write count", tag), 128'(n_writes - w_start), 128'(c_NR + 1));
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int w_start;
    w_start = n_writes;
    repeat (cycles) @(negedge clock);
    #1;
    check($sformatf("%s no writes", tag), 128'(n_writes - w_start), 128'h0);
    check($sformatf("%s busy low", tag), {127'h0, bus.busy}, 128'h0);
  endtask

  initial begin
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.key   = '0;
    build_sbox();

    // Reset state.
    repeat (3) @(negedge clock);
    check("rst we",    {127'h0, bus.we},   128'h0);
    check("rst wadd",  {124'h0, bus.wadd}, 128'h0);
    check("rst wdata", bus.wdata,          128'h0);
    check("rst busy",  {127'h0, bus.busy}, 128'h0);
    check("rst done",  {127'h0, bus.done}, 128'h0);
    reset_n = 1'b1;
    @(negedge clock);

    // FIPS-197 example key.
    bus.start = 1'b1;
    bus.key   = c_KEY_FIPS;
    run_seq(c_KEY_FIPS, "fips", 1'b0, 0);
    check("fips rk1 hand",  got[1],  128'ha0fafe1788542cb123a339392a6c7605);
    check("fips rk10 hand", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    expect_quiet("fips idle", 3);

    // All-zero key.
    @(negedge clock);
    bus.start = 1'b1;
    bus.key   = c_KEY_ZERO;
    run_seq(c_KEY_ZERO, "zero", 1'b0, 0);
    check("zero rk1 hand",  got[1],  128'h62636363626363636263636362636363);
    check("zero rk10 hand", got[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    expect_quiet("zero idle", 3);

    // start re-pulsed with another key at write 5: ignored.
    @(negedge clock);
    bus.start = 1'b1;
    bus.key   = c_KEY_FIPS;
    run_seq(c_KEY_FIPS, "poke", 1'b0, 6);
    check("poke rk10 hand", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    expect_quiet("poke idle", 4);

    // Reset asserted during write 4 aborts at once.
    @(negedge clock);
    bus.start = 1'b1;
    bus.key   = c_KEY_FIPS;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (4) @(negedge clock);
    check("abort at wadd4", {124'h0, bus.wadd}, 128'h4);
    #2 reset_n = 1'b0;
    #1;
    check("abort we",   {127'h0, bus.we},   128'h0);
    check("abort busy", {127'h0, bus.busy}, 128'h0);
    check("abort done", {127'h0, bus.done}, 128'h0);
    @(negedge clock);
    reset_n = 1'b1;
    expect_quiet("after abort", 6);

    // start held high across two back-to-back runs.
    @(negedge clock);
    bus.start = 1'b1;
    bus.key   = c_KEY_FIPS;
    run_seq(c_KEY_FIPS, "hold1", 1'b1, 0);
    @(negedge clock);
    check("hold gap we",   {127'h0, bus.we},   128'h0);
    check("hold gap done", {127'h0, bus.done}, 128'h0);
    run_seq(c_KEY_FIPS, "hold2", 1'b1, 0);
    bus.start = 1'b0;
    check("hold2 rk1 hand", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
    expect_quiet("hold end", 4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
